// File: rtl/dmem_arbiter_if.sv
// Bus bundle for dmem_arbiter: CPU MEM-stage port, DMA master port, DataMem port and stats.
// slave = arbiter view, master = the surrounding system (pipeline, DMA engine, memory).
interface dmem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              cpu_rd;
  logic              cpu_wr;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_stall;

  logic              dma_req;
  logic              dma_we;
  logic [ADDR_W-1:0] dma_addr;
  logic [DATA_W-1:0] dma_wdata;
  logic              dma_gnt;
  logic [DATA_W-1:0] dma_rdata;
  logic              dma_rvalid;

  logic              mem_rd;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic [15:0]       stat_stall;
  logic [15:0]       stat_dma;

  modport slave (
    input  cpu_rd, cpu_wr, cpu_addr, cpu_wdata,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    input  mem_rdata,
    output cpu_rdata, cpu_stall,
    output dma_gnt, dma_rdata, dma_rvalid,
    output mem_rd, mem_wr, mem_addr, mem_wdata,
    output stat_stall, stat_dma
  );

  modport master (
    output cpu_rd, cpu_wr, cpu_addr, cpu_wdata,
    output dma_req, dma_we, dma_addr, dma_wdata,
    output mem_rdata,
    input  cpu_rdata, cpu_stall,
    input  dma_gnt, dma_rdata, dma_rvalid,
    input  mem_rd, mem_wr, mem_addr, mem_wdata,
    input  stat_stall, stat_dma
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: CPU has priority, DMA is forced in after MAX_WAIT denied cycles.
// Optional saturating stall/grant counters are enabled by defining DMEM_ARB_STATS_EN.
module dmem_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 4
) (
  input logic         clk,
  input logic         reset,
  dmem_arbiter_if.slave bus
);

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);

  typedef enum logic {
    ARB_NORMAL,
    ARB_FORCE
  } arb_state_e;

  arb_state_e        state;
  logic [WAIT_W-1:0] wait_cnt;
  logic              cpu_req;
  logic              cpu_gnt;
  logic              dma_gnt;
  logic              dma_rd_gnt;
  logic [ADDR_W-1:0] addr_mux;
  logic [DATA_W-1:0] wdata_mux;
  logic              dma_rvalid_q;
  logic [DATA_W-1:0] dma_rdata_q;

  assign cpu_req = bus.cpu_rd | bus.cpu_wr;

  always_comb begin
    // NOTE: every signal gets a default first so no path can infer a latch.
    dma_gnt   = 1'b0;
    addr_mux  = bus.cpu_addr;
    wdata_mux = bus.cpu_wdata;
    if (state == ARB_FORCE) begin
      // A dropped request in the forced slot hands the cycle back to the CPU.
      dma_gnt = bus.dma_req;
    end else begin
      dma_gnt = bus.dma_req & ~cpu_req;
    end
    if (dma_gnt) begin
      addr_mux  = bus.dma_addr;
      wdata_mux = bus.dma_wdata;
    end
  end

  assign cpu_gnt    = cpu_req & ~dma_gnt;
  assign dma_rd_gnt = dma_gnt & ~bus.dma_we;

  assign bus.mem_rd     = (cpu_gnt & bus.cpu_rd) | dma_rd_gnt;
  assign bus.mem_wr     = (cpu_gnt & bus.cpu_wr) | (dma_gnt & bus.dma_we);
  assign bus.mem_addr   = addr_mux;
  assign bus.mem_wdata  = wdata_mux;
  assign bus.cpu_rdata  = bus.mem_rdata;
  assign bus.cpu_stall  = cpu_req & dma_gnt;
  assign bus.dma_gnt    = dma_gnt;
  assign bus.dma_rdata  = dma_rdata_q;
  assign bus.dma_rvalid = dma_rvalid_q;

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ARB_NORMAL;
      wait_cnt     <= '0;
      dma_rvalid_q <= 1'b0;
      dma_rdata_q  <= '0;
    end else begin
      dma_rvalid_q <= dma_rd_gnt;
      if (dma_rd_gnt) begin
        dma_rdata_q <= bus.mem_rdata;
      end
      unique case (state)
        ARB_NORMAL: begin
          if (bus.dma_req && cpu_req) begin
            if (wait_cnt == WAIT_W'(MAX_WAIT - 1)) begin
              state    <= ARB_FORCE;
              wait_cnt <= '0;
            end else begin
              wait_cnt <= wait_cnt + WAIT_W'(1);
            end
          end else begin
            wait_cnt <= '0;
          end
        end
        ARB_FORCE: begin
          state    <= ARB_NORMAL;
          wait_cnt <= '0;
        end
        default: begin
          state    <= ARB_NORMAL;
          wait_cnt <= '0;
        end
      endcase
    end
  end

`ifdef DMEM_ARB_STATS_EN
  logic [15:0] stall_cnt;
  logic [15:0] dma_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
      dma_cnt   <= '0;
    end else begin
      if (bus.cpu_stall && (stall_cnt != 16'hFFFF)) begin
        stall_cnt <= stall_cnt + 16'd1;
      end
      if (dma_gnt && (dma_cnt != 16'hFFFF)) begin
        dma_cnt <= dma_cnt + 16'd1;
      end
    end
  end

  assign bus.stat_stall = stall_cnt;
  assign bus.stat_dma   = dma_cnt;
`else
  assign bus.stat_stall = 16'h0;
  assign bus.stat_dma   = 16'h0;
`endif

  a_one_master: assert property (@(posedge clk) disable iff (reset) !(cpu_gnt && dma_gnt));
  a_rd_wr_excl: assert property (@(posedge clk) disable iff (reset) !(bus.mem_rd && bus.mem_wr));
  a_stall_req:  assert property (@(posedge clk) disable iff (reset) bus.cpu_stall |-> cpu_req);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: vector table plus contention/reset sequences,
// with a scoreboard queue for the delayed DMA read data.
module tb_dmem_arbiter;

  localparam int ADDR_W   = 32;
  localparam int DATA_W   = 32;
  localparam int MAX_WAIT = 4;

  localparam logic [31:0] A10    = 32'h10;
  localparam logic [31:0] A20    = 32'h20;
  localparam logic [31:0] A30    = 32'h30;
  localparam logic [31:0] A44    = 32'h44;
  localparam logic [31:0] D_INIT = 32'h1234_5678;
  localparam logic [31:0] D_BEEF = 32'hDEAD_BEEF;
  localparam logic [31:0] D_CAFE = 32'hCAFE_F00D;

`ifdef DMEM_ARB_STATS_EN
  localparam logic [31:0] EXP_STAT = 32'd2;
`else
  localparam logic [31:0] EXP_STAT = 32'd0;
`endif

  typedef struct {
    logic        cpu_rd;
    logic        cpu_wr;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic        dma_req;
    logic        dma_we;
    logic [31:0] dma_addr;
    logic [31:0] dma_wdata;
    logic        e_mem_rd;
    logic        e_mem_wr;
    logic [31:0] e_mem_addr;
    logic        e_stall;
    logic        e_gnt;
    logic [31:0] e_rdata;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  logic [31:0] rd_q[$];
  logic [31:0] mem [0:255];
  vec_t        tbl [26];
  vec_t        v_idle, v_both, v_frc, v_nodma;

  always #5 clk = ~clk;

  dmem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  dmem_arbiter #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .MAX_WAIT(MAX_WAIT)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // Small DataMem model: combinational read, write at the clock edge.
  assign bus.mem_rdata = mem[bus.mem_addr[7:0]];
  always @(posedge clk) begin
    if (bus.mem_wr) mem[bus.mem_addr[7:0]] <= bus.mem_wdata;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input int crd, input int cwr, input logic [31:0] ca, input logic [31:0] cwd,
                              input int dr, input int dwe, input logic [31:0] da, input logic [31:0] dwd,
                              input int erd, input int ewr, input logic [31:0] ea,
                              input int est, input int eg, input logic [31:0] erdata);
    vec_t t;
    t.cpu_rd = (crd != 0);  t.cpu_wr = (cwr != 0);  t.cpu_addr = ca;  t.cpu_wdata = cwd;
    t.dma_req = (dr != 0);  t.dma_we = (dwe != 0);  t.dma_addr = da;  t.dma_wdata = dwd;
    t.e_mem_rd = (erd != 0); t.e_mem_wr = (ewr != 0); t.e_mem_addr = ea;
    t.e_stall = (est != 0); t.e_gnt = (eg != 0); t.e_rdata = erdata;
    return t;
  endfunction

  task automatic drive(input vec_t t);
    bus.cpu_rd    = t.cpu_rd;
    bus.cpu_wr    = t.cpu_wr;
    bus.cpu_addr  = t.cpu_addr;
    bus.cpu_wdata = t.cpu_wdata;
    bus.dma_req   = t.dma_req;
    bus.dma_we    = t.dma_we;
    bus.dma_addr  = t.dma_addr;
    bus.dma_wdata = t.dma_wdata;
  endtask

  // One cycle: drive on the falling edge, check 1 time unit later, before the next rising edge.
  task automatic apply(input vec_t t, input string tag);
    @(negedge clk);
    drive(t);
    #1;
    if (rd_q.size() > 0) begin
      check({tag, ".rvalid"}, 32'(bus.dma_rvalid), 32'd1);
      check({tag, ".dma_rdata"}, bus.dma_rdata, rd_q.pop_front());
    end else begin
      check({tag, ".rvalid"}, 32'(bus.dma_rvalid), 32'd0);
    end
    check({tag, ".mem_rd"},    32'(bus.mem_rd),    32'(t.e_mem_rd));
    check({tag, ".mem_wr"},    32'(bus.mem_wr),    32'(t.e_mem_wr));
    check({tag, ".mem_addr"},  bus.mem_addr,       t.e_mem_addr);
    check({tag, ".cpu_stall"}, 32'(bus.cpu_stall), 32'(t.e_stall));
    check({tag, ".dma_gnt"},   32'(bus.dma_gnt),   32'(t.e_gnt));
    check({tag, ".cpu_rdata"}, bus.cpu_rdata,      t.e_rdata);
    if (t.e_gnt && !t.dma_we) rd_q.push_back(t.e_rdata);
  endtask

  // CPU and DMA both requesting: DMA is forced in every fifth cycle.
  task automatic contend(input int n, input string tag);
    for (int k = 0; k < n; k++) begin
      apply(((k % 5) == 4) ? v_frc : v_both, $sformatf("%s%0d", tag, k));
    end
  endtask

  // Short asynchronous reset between edges with idle inputs.
  task automatic pulse_reset();
    drive(v_idle);
    #1 reset = 1'b1;
    rd_q.delete();
    #1 reset = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[8'h10] = D_INIT;

    v_idle  = mk(0, 0, 0,   0, 0, 0, 0,   0, 0, 0, 0,   0, 0, 0);
    v_both  = mk(1, 0, A10, 0, 1, 0, A20, 0, 1, 0, A10, 0, 0, D_INIT);
    v_frc   = mk(1, 0, A10, 0, 1, 0, A20, 0, 1, 0, A20, 1, 1, D_BEEF);
    v_nodma = mk(1, 0, A10, 0, 0, 0, A20, 0, 1, 0, A10, 0, 0, D_INIT);

    drive(v_idle);
    #3;
    check("reset.rvalid",     32'(bus.dma_rvalid), 32'd0);
    check("reset.dma_rdata",  bus.dma_rdata,       32'd0);
    check("reset.stat_stall", 32'(bus.stat_stall), 32'd0);
    check("reset.stat_dma",   32'(bus.stat_dma),   32'd0);
    check("reset.dma_gnt",    32'(bus.dma_gnt),    32'd0);
    @(negedge clk);
    reset = 1'b0;

    tbl[0]  = mk(1, 0, A10, 0,      0, 0, 0,   0,      1, 0, A10, 0, 0, D_INIT);
    tbl[1]  = mk(0, 0, 0,   0,      1, 1, A20, D_BEEF, 0, 1, A20, 0, 1, 0);
    tbl[2]  = mk(0, 0, 0,   0,      1, 0, A20, 0,      1, 0, A20, 0, 1, D_BEEF);
    tbl[3]  = mk(0, 0, A44, 0,      0, 0, 0,   0,      0, 0, A44, 0, 0, 0);
    tbl[4]  = mk(0, 1, A30, D_CAFE, 0, 0, 0,   0,      0, 1, A30, 0, 0, 0);
    tbl[5]  = mk(1, 0, A30, 0,      0, 0, 0,   0,      1, 0, A30, 0, 0, D_CAFE);
    tbl[6]  = mk(0, 0, 0,   0,      1, 0, A30, 0,      1, 0, A30, 0, 1, D_CAFE);
    tbl[7]  = mk(0, 0, 0,   0,      1, 0, A10, 0,      1, 0, A10, 0, 1, D_INIT);
    tbl[8]  = v_idle;
    tbl[9]  = v_idle;
    tbl[10] = v_both;
    tbl[11] = v_both;
    tbl[12] = v_nodma;
    for (int i = 13; i <= 16; i++) tbl[i] = v_both;
    tbl[17] = v_frc;
    tbl[18] = v_both;
    tbl[19] = v_idle;
    for (int i = 20; i <= 23; i++) tbl[i] = v_both;
    tbl[24] = v_nodma;
    tbl[25] = v_both;

    for (int i = 0; i < 26; i++) apply(tbl[i], $sformatf("vec%0d", i));

    // Ten cycles of contention from reset, then the statistics.
    pulse_reset();
    contend(10, "cont");
    apply(v_idle, "cont_end");
    check("stat_stall", 32'(bus.stat_stall), EXP_STAT);
    check("stat_dma",   32'(bus.stat_dma),   EXP_STAT);

    // Reset held across the edge that would return the forced DMA read.
    pulse_reset();
    contend(5, "frc");
    #1 reset = 1'b1;
    rd_q.delete();
    #1;
    check("frc_rst.rvalid", 32'(bus.dma_rvalid), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    check("frc_rst.dma_rdata", bus.dma_rdata, 32'd0);
    contend(5, "post");

    // Reset mid-count: wait counter must restart from zero.
    contend(2, "pre");
    pulse_reset();
    contend(5, "rst");
    apply(v_idle, "drain");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
